mux16_arbiter: RTL and testbench
================================

# mux16_arbiter

Round-robin arbiter that shares one 16-input datapath mux (32-bit, 4-bit select) among 16 requesters. It grants exactly one requester at a time and drives the mux select from a registered owner index. It holds the grant until the owner signals completion, drops its request, or exceeds a programmable cycle budget. It sits between the requesting units (e.g. register-file read ports, memory-bus masters) and the mux select input.

## Interface
- TIMEOUT, 255: maximum cycles a grant may be held; 0 disables the timeout. Range 0..255.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  16  request vector; bit i = requester i wants the mux
- done  input  1  current owner finished; sampled only in BUSY
- sel  output  4  registered mux select = index of current/last owner
- grant  output  16  registered one-hot grant; all-zero when no owner
- valid  output  1  registered; high while a grant is active (grant != 0)
- timeout  output  1  registered one-cycle pulse on forced release

## Operation
- Reset: the interface is one clock, asynchronous active-low reset. While rst_n=0: sel=0, grant=0, valid=0, timeout=0, state=IDLE, round-robin pointer last=15 (requester 0 has top priority first), hold counter=0. Outputs clear immediately on rst_n fall, including mid-grant.
- States: IDLE, BUSY, GAP.
- IDLE: if req != 0, the winner is the first set bit searching last+1, last+2, … wrapping mod 16. At the clock edge: grant=1<<winner, sel=winner, valid=1, last=winner, counter=0, go BUSY. If req == 0, stay IDLE.
- BUSY release conditions are evaluated each cycle in priority order:
  1. done=1 → normal release.
  2. req[sel]=0 → abandon release, with no timeout pulse.
  3. TIMEOUT!=0 and counter==TIMEOUT-1 → forced release, timeout=1 for one cycle.
  4. Otherwise counter increments (saturating) and the state stays BUSY.
- Release (any cause): at the edge, grant=0, valid=0, go GAP. sel keeps the released index so the mux output stays stable.
- GAP: one mandatory dead cycle. Outputs stay idle, with no arbitration. The next edge returns to IDLE. timeout is cleared at the edge leaving GAP.
- The search in IDLE ignores state outside req. The just-released owner has lowest priority on the next arbitration.
- Requests changing during BUSY for non-owners have no effect.

## Timing
- Request-to-grant: req rises before edge k in IDLE → grant/valid high after edge k (1 cycle).
- Hold: the grant lasts from edge k until the edge at which a release condition is sampled.
- Back-to-back: the minimum spacing between two grants is 2 idle-output cycles. The release edge enters GAP and the next edge enters IDLE. Arbitration happens in IDLE, and the new grant appears 1 edge later. Sequence: BUSY → GAP → IDLE → BUSY.
- Timeout: with no done and req held, the forced release occurs on the edge where counter==TIMEOUT-1. The grant therefore lasts exactly TIMEOUT cycles. The timeout pulse is high for the single GAP cycle.
- done and timeout conditions in the same cycle: done wins, timeout stays 0.
- All outputs are registered; there is no combinational path from req/done to outputs.
- Counter width is 8 bits and saturates at 255. With TIMEOUT=0 it never forces release.

## Test plan
- Reset/idle: assert rst_n=0 mid-grant (owner 5) → grant=0, valid=0, sel=0 immediately. After release with req=16'h0001 → grant=16'h0001, sel=0 one edge later.
- Round-robin fairness: req=16'hFFFF held, each owner pulses done 1 cycle after grant → sel sequence 0,1,2,…,15,0. Each grant is separated by GAP then IDLE.
- Wrap and skip: last=14, req=16'h0009 → sel=0 (wrap past 15). Next arbitration with the same req → sel=3.
- Timeout: TIMEOUT=4, req=16'h0100 held, done=0 → grant=16'h0100 for exactly 4 cycles, then valid=0 with timeout=1 for 1 cycle. Requester 8 is re-granted after IDLE.
- Simultaneous/abandon: TIMEOUT=3 with done=1 on the 3rd BUSY cycle → release with timeout=0. Separately, the owner drops req mid-grant → release next edge with timeout=0.
- TIMEOUT=0: hold req for 1000 cycles with no done → grant never released, timeout never pulses.

Source files
------------

// File: rtl/mux16_arbiter_if.sv
// Request/grant bundle between the requesters and the shared 16:1 mux arbiter.
// The master side drives req/done; the slave (arbiter) side drives sel/grant/valid/timeout.
interface mux16_arbiter_if;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        valid;
    logic        timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  grant,
        input  valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output grant,
        output valid,
        output timeout
    );
endinterface

// File: rtl/mux16_arbiter.sv
// Round-robin owner of a 16:1 mux select; grant is registered 1 cycle after req, then held
// until done, the request drops, or the TIMEOUT budget is spent (no backpressure, req is level).
module mux16_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    mux16_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] grant_q, grant_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;

    logic [3:0]  win_idx;
    logic [3:0]  cand;
    logic        win_vld;

    // Scan from last+16 (== last, lowest priority) down to last+1 so the
    // nearest set bit after the previous owner is the final assignment.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        win_vld = |bus.req;
        for (int i = 16; i >= 1; i--) begin
            cand = last_q + 4'(i);
            if (bus.req[cand]) begin
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;

        unique case (state_q)
            IDLE: begin
                timeout_d = 1'b0;
                if (win_vld) begin
                    grant_d = 16'b1 << win_idx;
                    sel_d   = win_idx;
                    valid_d = 1'b1;
                    last_d  = win_idx;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.done || !bus.req[sel_q]) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    state_d = GAP;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            GAP: begin
                // sel stays on the released index so the mux output does not glitch.
                timeout_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                grant_d   = '0;
                valid_d   = 1'b0;
                timeout_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 4'd15;
            cnt_q     <= 8'd0;
            sel_q     <= 4'd0;
            grant_q   <= 16'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.grant   = grant_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux16_arbiter.sv
// Drives three arbiters (TIMEOUT 4, 3, 0) with shared req/done and checks every cycle
// against an ownership-level reference model, plus directed checks on the key scenarios.
module tb_mux16_arbiter;

    localparam int TOS [3] = '{4, 3, 0};

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;

    int checks;
    int errors;

    mux16_arbiter_if u_if0 ();
    mux16_arbiter_if u_if1 ();
    mux16_arbiter_if u_if2 ();

    assign u_if0.req  = req;
    assign u_if1.req  = req;
    assign u_if2.req  = req;
    assign u_if0.done = done;
    assign u_if1.done = done;
    assign u_if2.done = done;

    mux16_arbiter #(.TIMEOUT(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0));
    mux16_arbiter #(.TIMEOUT(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));
    mux16_arbiter #(.TIMEOUT(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2));

    logic [3:0]  d_sel   [3];
    logic [15:0] d_grant [3];
    logic        d_valid [3];
    logic        d_to    [3];

    assign d_sel[0]   = u_if0.sel;
    assign d_sel[1]   = u_if1.sel;
    assign d_sel[2]   = u_if2.sel;
    assign d_grant[0] = u_if0.grant;
    assign d_grant[1] = u_if1.grant;
    assign d_grant[2] = u_if2.grant;
    assign d_valid[0] = u_if0.valid;
    assign d_valid[1] = u_if1.valid;
    assign d_valid[2] = u_if2.valid;
    assign d_to[0]    = u_if0.timeout;
    assign d_to[1]    = u_if1.timeout;
    assign d_to[2]    = u_if2.timeout;

    // Reference model: who owns the mux, how long they have held it, and whether
    // the mandatory dead cycle is still pending before the next arbitration.
    int   m_owner [3];
    int   m_last  [3];
    int   m_held  [3];
    int   m_sel   [3];
    bit   m_gap   [3];
    bit   m_tp    [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_owner[n] = -1;
            m_last[n]  = 15;
            m_held[n]  = 0;
            m_sel[n]   = 0;
            m_gap[n]   = 1'b0;
            m_tp[n]    = 1'b0;
        end
    endtask

    task automatic model_release(input int n, input bit forced);
        m_owner[n] = -1;
        m_gap[n]   = 1'b1;
        m_tp[n]    = forced;
    endtask

    task automatic model_step();
        int idx;
        for (int n = 0; n < 3; n++) begin
            if (m_owner[n] >= 0) begin
                m_held[n]++;
                if (done)
                    model_release(n, 1'b0);
                else if (!req[m_owner[n]])
                    model_release(n, 1'b0);
                else if (TOS[n] != 0 && m_held[n] == TOS[n])
                    model_release(n, 1'b1);
            end else if (m_gap[n]) begin
                m_gap[n] = 1'b0;
                m_tp[n]  = 1'b0;
            end else if (req != 16'h0) begin
                idx = -1;
                for (int k = 1; k <= 16; k++) begin
                    if (idx < 0 && req[(m_last[n] + k) % 16]) idx = (m_last[n] + k) % 16;
                end
                m_owner[n] = idx;
                m_last[n]  = idx;
                m_sel[n]   = idx;
                m_held[n]  = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] one16;
        logic [15:0] exp_g;
        one16 = 16'h1;
        for (int n = 0; n < 3; n++) begin
            exp_g = 16'h0;
            if (m_owner[n] >= 0) exp_g = one16 << m_owner[n];
            chk($sformatf("grant%0d", n), 32'(d_grant[n]), 32'(exp_g));
            chk($sformatf("valid%0d", n), 32'(d_valid[n]), 32'(m_owner[n] >= 0));
            chk($sformatf("sel%0d", n), 32'(d_sel[n]), 32'(m_sel[n]));
            chk($sformatf("timeout%0d", n), 32'(d_to[n]), 32'(m_tp[n]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int budget);
        int k;
        k = 0;
        while (d_valid[0] !== 1'b1 && k < budget) begin
            cycle();
            k++;
        end
        chk("grant_wait", 32'(d_valid[0]), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_grants;
        int  hold;
        int  to_seen;
        bit  prev_v;
        int  pick;

        checks = 0;
        errors = 0;
        req    = 16'h0;
        done   = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        #2;
        apply_reset();
        chk("rst_sel", 32'(d_sel[0]), 32'd0);
        chk("rst_valid", 32'(d_valid[0]), 32'd0);

        // Owner 5 then an asynchronous reset in the middle of the grant.
        req = 16'h0020;
        wait_grant(5);
        chk("own5_sel", 32'(d_sel[0]), 32'd5);
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_grant", 32'(d_grant[0]), 32'd0);
        chk("arst_valid", 32'(d_valid[0]), 32'd0);
        chk("arst_sel", 32'(d_sel[0]), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 16'h0001;
        cycle();
        chk("post_rst_grant", 32'(d_grant[0]), 32'h0001);
        chk("post_rst_sel", 32'(d_sel[0]), 32'd0);

        // Round-robin over all requesters, each releasing with done after one cycle.
        req = 16'h0;
        apply_reset();
        req      = 16'hFFFF;
        n_grants = 0;
        prev_v   = 1'b0;
        for (int c = 0; c < 60; c++) begin
            done = (m_owner[0] >= 0);
            cycle();
            if (d_valid[0] === 1'b1 && !prev_v) begin
                chk($sformatf("rr_sel_%0d", n_grants), 32'(d_sel[0]), 32'(n_grants % 16));
                n_grants++;
            end
            prev_v = d_valid[0];
        end
        chk("rr_count", 32'(n_grants >= 17), 32'd1);
        done = 1'b0;

        // Wrap past 15 and skip unrequested indices.
        req = 16'h0;
        apply_reset();
        req = 16'h4000;
        wait_grant(5);
        chk("wrap_own14", 32'(d_sel[0]), 32'd14);
        done = 1'b1;
        cycle();
        done = 1'b0;
        req  = 16'h0009;
        chk("wrap_keep_sel", 32'(d_sel[0]), 32'd14);
        wait_grant(5);
        chk("wrap_sel0", 32'(d_sel[0]), 32'd0);
        done = 1'b1;
        cycle();
        done = 1'b0;
        wait_grant(5);
        chk("skip_sel3", 32'(d_sel[0]), 32'd3);

        // Forced release after exactly TIMEOUT=4 cycles on the first instance.
        req  = 16'h0;
        apply_reset();
        req = 16'h0100;
        wait_grant(5);
        hold = 0;
        do begin
            hold++;
            cycle();
        end while (d_valid[0] === 1'b1 && hold < 20);
        chk("to_hold_len", 32'(hold), 32'd4);
        chk("to_pulse", 32'(d_to[0]), 32'd1);
        cycle();
        chk("to_pulse_end", 32'(d_to[0]), 32'd0);
        wait_grant(5);
        chk("to_regrant", 32'(d_sel[0]), 32'd8);

        // done in the same cycle the TIMEOUT=3 budget expires: done wins.
        req = 16'h0;
        apply_reset();
        req = 16'h0004;
        wait_grant(5);
        cycle();
        cycle();
        done = 1'b1;
        cycle();
        done = 1'b0;
        chk("sim_valid1", 32'(d_valid[1]), 32'd0);
        chk("sim_to1", 32'(d_to[1]), 32'd0);

        // Owner abandons its request mid-grant.
        req = 16'h0;
        apply_reset();
        req = 16'h0004;
        wait_grant(5);
        cycle();
        req = 16'h0;
        cycle();
        chk("abandon_valid", 32'(d_valid[2]), 32'd0);
        chk("abandon_to", 32'(d_to[0]), 32'd0);

        // TIMEOUT=0 instance must keep its grant indefinitely.
        apply_reset();
        req     = 16'h0002;
        to_seen = 0;
        for (int c = 0; c < 1000; c++) begin
            cycle();
            if (d_to[2] === 1'b1) to_seen++;
        end
        chk("nto_valid", 32'(d_valid[2]), 32'd1);
        chk("nto_sel", 32'(d_sel[2]), 32'd1);
        chk("nto_pulses", 32'(to_seen), 32'd0);

        // Random traffic against the model.
        req = 16'h0;
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            pick = int'($urandom_range(0, 4));
            case (pick)
                0: req = 16'h0;
                1: req = 16'h1 << $urandom_range(0, 15);
                2: req = 16'($urandom);
                default: ;
            endcase
            done = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
